// File: rtl/npu_pkg.sv
// Shared types for the graph DMA shim: FSM state encoding and direction codes.
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        SRAM_WR,
        SRAM_RD,
        SRAM_WAIT,
        WR_REQ,
        DONE
    } dma_state_e;

    localparam logic DMA_DIR_LOAD  = 1'b0;
    localparam logic DMA_DIR_STORE = 1'b1;

endpackage

// File: rtl/graph_dma_shim_if.sv
// Command, DDR byte-port and SRAM0 signals of the graph DMA shim.
// slave = the shim's view, master = the dispatch/memory side.
interface graph_dma_shim_if #(
    parameter int DDR_AW   = 32,
    parameter int SRAM0_AW = 16
);
    logic                cmd_valid;
    logic [DDR_AW-1:0]   cmd_ddr_addr;
    logic [15:0]         cmd_sram_addr;
    logic [15:0]         cmd_length;
    logic                cmd_direction;
    logic                cmd_strided;
    logic [31:0]         cmd_stride;
    logic [15:0]         cmd_count;
    logic [15:0]         cmd_block_len;
    logic                done;
    logic                busy;
    logic                ddr_rd_req;
    logic [DDR_AW-1:0]   ddr_rd_addr;
    logic                ddr_rd_gnt;
    logic                ddr_rd_valid;
    logic [7:0]          ddr_rd_data;
    logic                ddr_wr_req;
    logic [DDR_AW-1:0]   ddr_wr_addr;
    logic [7:0]          ddr_wr_data;
    logic                ddr_wr_gnt;
    logic                sram_rd_en;
    logic [SRAM0_AW-1:0] sram_rd_addr;
    logic [7:0]          sram_rd_data;
    logic                sram_wr_en;
    logic [SRAM0_AW-1:0] sram_wr_addr;
    logic [7:0]          sram_wr_data;

    modport slave (
        input  cmd_valid, cmd_ddr_addr, cmd_sram_addr, cmd_length, cmd_direction,
               cmd_strided, cmd_stride, cmd_count, cmd_block_len,
               ddr_rd_gnt, ddr_rd_valid, ddr_rd_data, ddr_wr_gnt, sram_rd_data,
        output done, busy, ddr_rd_req, ddr_rd_addr, ddr_wr_req, ddr_wr_addr, ddr_wr_data,
               sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data
    );

    modport master (
        output cmd_valid, cmd_ddr_addr, cmd_sram_addr, cmd_length, cmd_direction,
               cmd_strided, cmd_stride, cmd_count, cmd_block_len,
               ddr_rd_gnt, ddr_rd_valid, ddr_rd_data, ddr_wr_gnt, sram_rd_data,
        input  done, busy, ddr_rd_req, ddr_rd_addr, ddr_wr_req, ddr_wr_addr, ddr_wr_data,
               sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data
    );
endinterface

// File: rtl/graph_dma_shim_agen.sv
// Byte/block counters and DDR/SRAM0 address generation for one transfer.
// i_load captures the normalised command; i_step advances one byte.
module graph_dma_agen #(
    parameter int DDR_AW   = 32,
    parameter int SRAM0_AW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [DDR_AW-1:0]   i_ddr_addr,
    input  logic [SRAM0_AW-1:0] i_sram_addr,
    input  logic [31:0]         i_stride,
    input  logic [15:0]         i_count,
    input  logic [15:0]         i_block_len,
    output logic [DDR_AW-1:0]   o_ddr_addr,
    output logic [SRAM0_AW-1:0] o_sram_addr,
    output logic                o_last_byte,
    output logic                o_last_block
);
    logic [DDR_AW-1:0]   r_ddr_base;
    logic [SRAM0_AW-1:0] r_sram_ptr;
    logic [31:0]         r_stride;
    logic [15:0]         r_count;
    logic [15:0]         r_block_len;
    logic [15:0]         r_byte_cnt;
    logic [15:0]         r_blk_cnt;

    // SRAM side is packed, so a single running pointer covers block boundaries.
    assign o_ddr_addr   = r_ddr_base + DDR_AW'(r_byte_cnt);
    assign o_sram_addr  = r_sram_ptr;
    assign o_last_byte  = (r_byte_cnt == r_block_len - 16'd1);
    assign o_last_block = (r_blk_cnt == r_count - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ddr_base  <= '0;
            r_sram_ptr  <= '0;
            r_stride    <= '0;
            r_count     <= '0;
            r_block_len <= '0;
            r_byte_cnt  <= '0;
            r_blk_cnt   <= '0;
        end else if (i_load) begin
            r_ddr_base  <= i_ddr_addr;
            r_sram_ptr  <= i_sram_addr;
            r_stride    <= i_stride;
            r_count     <= i_count;
            r_block_len <= i_block_len;
            r_byte_cnt  <= '0;
            r_blk_cnt   <= '0;
        end else if (i_step) begin
            r_sram_ptr <= r_sram_ptr + SRAM0_AW'(1);
            if (o_last_byte) begin
                r_byte_cnt <= '0;
                r_blk_cnt  <= r_blk_cnt + 16'd1;
                r_ddr_base <= r_ddr_base + DDR_AW'(r_stride);
            end else begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/graph_dma_shim.sv
// Executes dispatch DMA commands byte by byte between DDR and SRAM0, contiguous or 2-D strided.
// One transfer at a time, one DDR request outstanding; done pulses for one cycle at the end.
module graph_dma_shim
    import npu_pkg::*;
#(
    parameter int SRAM0_AW = 16,
    parameter int DDR_AW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    graph_dma_shim_if.slave  bus
);
    dma_state_e          r_state;
    dma_state_e          w_next;
    logic [7:0]          r_data;
    logic [15:0]         w_count;
    logic [15:0]         w_blen;
    logic                w_zero;
    logic                w_accept;
    logic                w_step;
    logic                w_last_byte;
    logic                w_last_block;
    logic                w_last;
    logic [DDR_AW-1:0]   w_ddr_addr;
    logic [SRAM0_AW-1:0] w_sram_addr;

    // Contiguous mode is one block of cmd_length bytes.
    assign w_count  = bus.cmd_strided ? bus.cmd_count : 16'd1;
    assign w_blen   = bus.cmd_strided ? bus.cmd_block_len : bus.cmd_length;
    assign w_zero   = (w_count == 16'd0) || (w_blen == 16'd0);
    assign w_accept = bus.cmd_valid && ((r_state == IDLE) || (r_state == DONE));
    assign w_step   = (r_state == SRAM_WR) || ((r_state == WR_REQ) && bus.ddr_wr_gnt);
    assign w_last   = w_last_byte && w_last_block;

    graph_dma_agen #(
        .DDR_AW   (DDR_AW),
        .SRAM0_AW (SRAM0_AW)
    ) u_agen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_accept),
        .i_step       (w_step),
        .i_ddr_addr   (bus.cmd_ddr_addr),
        .i_sram_addr  (bus.cmd_sram_addr[SRAM0_AW-1:0]),
        .i_stride     (bus.cmd_stride),
        .i_count      (w_count),
        .i_block_len  (w_blen),
        .o_ddr_addr   (w_ddr_addr),
        .o_sram_addr  (w_sram_addr),
        .o_last_byte  (w_last_byte),
        .o_last_block (w_last_block)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == RD_WAIT) && bus.ddr_rd_valid) begin
                r_data <= bus.ddr_rd_data;
            end else if (r_state == SRAM_WAIT) begin
                r_data <= bus.sram_rd_data;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.done         = 1'b0;
        bus.busy         = 1'b0;
        bus.ddr_rd_req   = 1'b0;
        bus.ddr_rd_addr  = '0;
        bus.ddr_wr_req   = 1'b0;
        bus.ddr_wr_addr  = '0;
        bus.ddr_wr_data  = '0;
        bus.sram_rd_en   = 1'b0;
        bus.sram_rd_addr = '0;
        bus.sram_wr_en   = 1'b0;
        bus.sram_wr_addr = '0;
        bus.sram_wr_data = '0;
        case (r_state)
            IDLE, DONE: begin
                bus.done = (r_state == DONE);
                if (w_accept) begin
                    if (w_zero)                                w_next = DONE;
                    else if (bus.cmd_direction == DMA_DIR_LOAD) w_next = RD_REQ;
                    else                                       w_next = SRAM_RD;
                end else begin
                    w_next = IDLE;
                end
            end
            RD_REQ: begin
                bus.busy        = 1'b1;
                bus.ddr_rd_req  = 1'b1;
                bus.ddr_rd_addr = w_ddr_addr;
                if (bus.ddr_rd_gnt) w_next = RD_WAIT;
            end
            RD_WAIT: begin
                bus.busy = 1'b1;
                if (bus.ddr_rd_valid) w_next = SRAM_WR;
            end
            SRAM_WR: begin
                bus.busy         = 1'b1;
                bus.sram_wr_en   = 1'b1;
                bus.sram_wr_addr = w_sram_addr;
                bus.sram_wr_data = r_data;
                w_next           = w_last ? DONE : RD_REQ;
            end
            SRAM_RD: begin
                bus.busy         = 1'b1;
                bus.sram_rd_en   = 1'b1;
                bus.sram_rd_addr = w_sram_addr;
                w_next           = SRAM_WAIT;
            end
            SRAM_WAIT: begin
                bus.busy = 1'b1;
                w_next   = WR_REQ;
            end
            WR_REQ: begin
                bus.busy        = 1'b1;
                bus.ddr_wr_req  = 1'b1;
                bus.ddr_wr_addr = w_ddr_addr;
                bus.ddr_wr_data = r_data;
                if (bus.ddr_wr_gnt) w_next = w_last ? DONE : SRAM_RD;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_graph_dma_shim.sv
// Self-checking bench for graph_dma_shim: DDR/SRAM0 models plus a write scoreboard.
module tb_graph_dma_shim;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    graph_dma_shim_if #(.DDR_AW(32), .SRAM0_AW(16)) bus ();

    graph_dma_shim #(.SRAM0_AW(16), .DDR_AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          is_ddr;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] ddr_mem  [0:65535];
    logic [7:0] sram_mem [0:65535];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    int rd_gnt_dly = 0;
    int rd_val_dly = 2;
    int wr_gnt_dly = 0;
    bit spur_valid = 1'b0;

    int          rd_gcnt, rd_vcnt, wr_cnt;
    bit          rd_pend, prev_wr_wait;
    logic [31:0] rd_paddr, prev_wr_addr;
    logic [7:0]  prev_wr_data;

    // Memory-side responders and output monitor; writes are scored as the DUT issues them.
    always @(negedge clk) begin
        bus.ddr_rd_gnt   = 1'b0;
        bus.ddr_rd_valid = 1'b0;
        bus.ddr_wr_gnt   = 1'b0;
        if (!rst_n) begin
            rd_pend = 0; rd_gcnt = 0; wr_cnt = 0; prev_wr_wait = 0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.ddr_rd_req || bus.ddr_wr_req || bus.sram_rd_en || bus.sram_wr_en) strobe_cnt++;
            if (bus.sram_rd_en && bus.sram_wr_en) begin
                checks++; errors++;
                $display("FAIL sram_strobes: rd_en and wr_en both high, required at most one");
            end
            if (bus.sram_rd_en) bus.sram_rd_data = sram_mem[bus.sram_rd_addr];
            if (bus.sram_wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_wr: unexpected write addr=%h data=%h, required none",
                             bus.sram_wr_addr, bus.sram_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_ddr || mon_e.addr[15:0] !== bus.sram_wr_addr || mon_e.data !== bus.sram_wr_data) begin
                        errors++;
                        $display("FAIL sram_wr: got addr=%h data=%h, required ddr=%0d addr=%h data=%h",
                                 bus.sram_wr_addr, bus.sram_wr_data, mon_e.is_ddr, mon_e.addr[15:0], mon_e.data);
                    end
                end
                sram_mem[bus.sram_wr_addr] = bus.sram_wr_data;
            end
            if (rd_pend) begin
                if (rd_vcnt == 0) begin
                    bus.ddr_rd_valid = 1'b1;
                    bus.ddr_rd_data  = ddr_mem[rd_paddr[15:0]];
                    rd_pend = 0;
                end else begin
                    rd_vcnt--;
                end
            end else if (bus.ddr_rd_req) begin
                if (rd_gcnt >= rd_gnt_dly) begin
                    bus.ddr_rd_gnt = 1'b1;
                    rd_pend  = 1;
                    rd_vcnt  = rd_val_dly - 1;
                    rd_paddr = bus.ddr_rd_addr;
                    rd_gcnt  = 0;
                    if (spur_valid) begin
                        bus.ddr_rd_valid = 1'b1;
                        bus.ddr_rd_data  = ~ddr_mem[rd_paddr[15:0]];
                    end
                end else begin
                    rd_gcnt++;
                end
            end
            if (bus.ddr_wr_req) begin
                if (prev_wr_wait) begin
                    checks++;
                    if (bus.ddr_wr_addr !== prev_wr_addr || bus.ddr_wr_data !== prev_wr_data) begin
                        errors++;
                        $display("FAIL wr_req_stable: got addr=%h data=%h, required addr=%h data=%h",
                                 bus.ddr_wr_addr, bus.ddr_wr_data, prev_wr_addr, prev_wr_data);
                    end
                end
                if (wr_cnt >= wr_gnt_dly) begin
                    bus.ddr_wr_gnt = 1'b1;
                    wr_cnt = 0;
                    prev_wr_wait = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL ddr_wr: unexpected write addr=%h data=%h, required none",
                                 bus.ddr_wr_addr, bus.ddr_wr_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (!mon_e.is_ddr || mon_e.addr !== bus.ddr_wr_addr || mon_e.data !== bus.ddr_wr_data) begin
                            errors++;
                            $display("FAIL ddr_wr: got addr=%h data=%h, required ddr=%0d addr=%h data=%h",
                                     bus.ddr_wr_addr, bus.ddr_wr_data, mon_e.is_ddr, mon_e.addr, mon_e.data);
                        end
                    end
                    ddr_mem[bus.ddr_wr_addr[15:0]] = bus.ddr_wr_data;
                end else begin
                    wr_cnt++;
                    prev_wr_wait = 1;
                    prev_wr_addr = bus.ddr_wr_addr;
                    prev_wr_data = bus.ddr_wr_data;
                end
            end else begin
                prev_wr_wait = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] out_vec();
        return {bus.done, bus.busy, bus.ddr_rd_req, bus.ddr_wr_req, bus.sram_rd_en, bus.sram_wr_en,
                (|bus.ddr_rd_addr) | (|bus.ddr_wr_addr) | (|bus.ddr_wr_data),
                (|bus.sram_rd_addr) | (|bus.sram_wr_addr) | (|bus.sram_wr_data)};
    endfunction

    // Pushes the expected write stream, then presents the command for one cycle.
    task automatic issue(input bit dir, input bit strided, input logic [31:0] ddr, input logic [15:0] sram,
                         input logic [15:0] len, input logic [31:0] stride, input logic [15:0] cnt,
                         input logic [15:0] blen);
        int nblk, nb;
        logic [31:0] da;
        logic [15:0] sa;
        wr_t e;
        nblk = strided ? int'(cnt) : 1;
        nb   = strided ? int'(blen) : int'(len);
        for (int k = 0; k < nblk; k++) begin
            for (int b = 0; b < nb; b++) begin
                da = ddr + 32'(k) * stride + 32'(b);
                sa = 16'(int'(sram) + k * nb + b);
                e.is_ddr = dir;
                if (!dir) begin e.addr = {16'd0, sa}; e.data = ddr_mem[da[15:0]]; end
                else      begin e.addr = da;          e.data = sram_mem[sa];      end
                exp_q.push_back(e);
            end
        end
        bus.cmd_direction = dir;   bus.cmd_strided   = strided;
        bus.cmd_ddr_addr  = ddr;   bus.cmd_sram_addr = sram;
        bus.cmd_length    = len;   bus.cmd_stride    = stride;
        bus.cmd_count     = cnt;   bus.cmd_block_len = blen;
        bus.cmd_valid     = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Returns with cyc = cycles after the accept cycle at which done was seen.
    task automatic wait_done(input string name, output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 400) begin tick(); cyc++; end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_vec() !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %b, required 00000000", out_vec()); end
        tick(); rst_n = 1'b1; tick(); tick();
        checks++;
        if (out_vec() !== 8'h00 || done_cnt !== 0) begin
            errors++; $display("FAIL idle_outputs: got %b done_cnt=%0d, required 00000000 and 0", out_vec(), done_cnt);
        end
    endtask

    task automatic test_contig_load();
        int d0, cyc;
        d0 = done_cnt;
        issue(1'b0, 1'b0, 32'h1000, 16'h0040, 16'd4, 32'd0, 16'd0, 16'd0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b, required 1", bus.busy); end
        wait_done("load", cyc);
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL load_end: busy=%b done=%b dones=%0d left=%0d, required 0 0 1 0",
                     bus.busy, bus.done, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_store_delayed();
        int d0, cyc;
        d0 = done_cnt;
        wr_gnt_dly = 3;
        issue(1'b1, 1'b0, 32'h2000, 16'h0010, 16'd3, 32'd0, 16'd0, 16'd0);
        wait_done("store", cyc);
        tick();
        wr_gnt_dly = 0;
        checks++;
        if (bus.busy !== 1'b0 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL store_end: busy=%b dones=%0d left=%0d, required 0 1 0", bus.busy, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_strided_load();
        int d0, cyc;
        d0 = done_cnt;
        spur_valid = 1'b1;
        rd_gnt_dly = 1;
        issue(1'b0, 1'b1, 32'h0100, 16'h0000, 16'd99, 32'h20, 16'd3, 16'd2);
        wait_done("strided", cyc);
        tick();
        spur_valid = 1'b0;
        rd_gnt_dly = 0;
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL strided_end: dones=%0d left=%0d, required 1 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_zero_length();
        int s0, cyc;
        bit          z_str [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] z_len [3] = '{16'd0, 16'd5, 16'd5};
        logic [15:0] z_cnt [3] = '{16'd3, 16'd0, 16'd4};
        logic [15:0] z_blen[3] = '{16'd2, 16'd2, 16'd0};
        for (int i = 0; i < 3; i++) begin
            s0 = strobe_cnt;
            issue(i[0], z_str[i], 32'h0800, 16'h0100, z_len[i], 32'h10, z_cnt[i], z_blen[i]);
            wait_done("zero", cyc);
            checks++;
            // No memory phase: done shows in the cycle right after the accept cycle.
            if (cyc != 1) begin errors++; $display("FAIL zero_latency[%0d]: got %0d, required 1", i, cyc); end
            tick();
            checks++;
            if (strobe_cnt != s0 || bus.done !== 1'b0) begin
                errors++; $display("FAIL zero_strobes[%0d]: strobes=%0d done=%b, required 0 0", i, strobe_cnt - s0, bus.done);
            end
        end
    endtask

    task automatic test_sram_wrap();
        int cyc;
        issue(1'b0, 1'b0, 32'h3000, 16'hFFFE, 16'd4, 32'd0, 16'd0, 16'd0);
        wait_done("wrap", cyc);
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_end: left=%0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d0, cyc;
        rd_val_dly = 6;
        issue(1'b0, 1'b0, 32'h4000, 16'h0400, 16'd8, 32'd0, 16'd0, 16'd0);
        repeat (5) tick();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vec() !== 8'h00) begin errors++; $display("FAIL midreset_outputs: got %b, required 00000000", out_vec()); end
        repeat (3) tick();
        exp_q.delete();
        rd_val_dly = 2;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_cnt != d0 || out_vec() !== 8'h00) begin
            errors++; $display("FAIL midreset_nodone: dones=%0d outs=%b, required 0 00000000", done_cnt - d0, out_vec());
        end
        issue(1'b0, 1'b0, 32'h4100, 16'h0500, 16'd2, 32'd0, 16'd0, 16'd0);
        wait_done("after_reset", cyc);
        tick();
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL after_reset_end: dones=%0d left=%0d, required 1 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        int d0, s0, cyc;
        d0 = done_cnt;
        issue(1'b0, 1'b0, 32'h5000, 16'h0200, 16'd3, 32'd0, 16'd0, 16'd0);
        tick(); tick();
        bus.cmd_direction = 1'b1; bus.cmd_ddr_addr = 32'h5800; bus.cmd_sram_addr = 16'h0600;
        bus.cmd_length = 16'd7;   bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        wait_done("ignore", cyc);
        tick();
        s0 = strobe_cnt;
        repeat (10) tick();
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || strobe_cnt != s0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: dones=%0d left=%0d strobes=%0d busy=%b, required 1 0 0 0",
                     done_cnt - d0, exp_q.size(), strobe_cnt - s0, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int d0, cyc;
        d0 = done_cnt;
        issue(1'b1, 1'b1, 32'h6000, 16'h0300, 16'd0, 32'h10, 16'd2, 16'd3);
        wait_done("b2b_store", cyc);
        // Present the next command during the DONE cycle.
        issue(1'b0, 1'b0, 32'h7000, 16'h0700, 16'd2, 32'd0, 16'd0, 16'd0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b, required 1", bus.busy); end
        wait_done("b2b_load", cyc);
        tick();
        checks++;
        if (done_cnt - d0 != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_end: dones=%0d left=%0d, required 2 0", done_cnt - d0, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ddr_mem[i]  = 8'(i * 7 + 3) ^ 8'(i >> 8);
            sram_mem[i] = 8'(i) ^ 8'h5A;
        end
        bus.cmd_valid = 1'b0;    bus.cmd_ddr_addr  = '0; bus.cmd_sram_addr = '0;
        bus.cmd_length = '0;     bus.cmd_direction = 1'b0; bus.cmd_strided = 1'b0;
        bus.cmd_stride = '0;     bus.cmd_count = '0;   bus.cmd_block_len = '0;
        bus.ddr_rd_gnt = 1'b0;   bus.ddr_rd_valid = 1'b0; bus.ddr_rd_data = '0;
        bus.ddr_wr_gnt = 1'b0;   bus.sram_rd_data = '0;
        test_reset();
        test_contig_load();
        test_store_delayed();
        test_strided_load();
        test_zero_length();
        test_sram_wrap();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
